// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake with programmable wait states.
// Optional address-range error reporting is compiled in by defining DMEM_RANGE_CHK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          we_reg;
    logic [3:0]    be_reg;
    logic [31:0]   wdata_reg;
    logic [AW-1:0] idx_reg;
    logic          oor_reg;
    logic          rsp_valid_reg;
    logic          rsp_err_reg;
    logic [31:0]   rsp_rdata_reg;

    logic          accept;
    logic          access;
    logic          rsp_done;
    logic          addr_oor;
    logic [7:0]    rd_lane [4];
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

`ifdef DMEM_RANGE_CHK_EN
    assign addr_oor = |(req_addr >> (AW + 2));
`else
    assign addr_oor = 1'b0;
`endif

    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        access     = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(WAIT_STATES);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces IDLE immediately, so a store still waiting never reaches the write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            be_reg        <= 4'd0;
            wdata_reg     <= 32'd0;
            idx_reg       <= '0;
            oor_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                be_reg    <= req_be;
                wdata_reg <= req_wdata;
                idx_reg   <= req_addr[2 +: AW];
                oor_reg   <= addr_oor;
            end
            if (access) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= oor_reg ? 32'd0 : rd_word;
                rsp_err_reg   <= oor_reg;
            end
            if (rsp_done) begin
                rsp_valid_reg <= 1'b0;
                rsp_err_reg   <= 1'b0;
            end
        end
    end

    // One byte-wide array per lane; the old word is read before the same-edge write lands.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (access && we_reg && be_reg[gi] && !oor_reg) begin
                    mem[idx_reg] <= wdata_reg[8*gi +: 8];
                end
            end

            assign rd_lane[gi] = mem[idx_reg];
        end
    endgenerate

    assign rd_word   = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipeline core's load/store requests over a valid/ready request/response handshake. It holds a word-organised data store with per-byte write enables and a programmable wait-state counter, so multi-cycle memory timing can be exercised. The core remains the initiator: it rotates store data into lanes and generates byte enables, and it sign/zero-extends load data. The block replaces the single-cycle data memory on the MEM side of the pipeline.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥ 2
- WAIT_STATES, 1, extra cycles between accept and the memory access; 0..15
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; [1:0] ignored
- req_be  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i]
- req_wdata  in  32  lane-aligned store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  32  raw memory word (no extension)
- rsp_err  out  1  address-range error; constant 0 unless the macro is defined

## Operation
- FSM states: IDLE, WAIT, RESP. `req_ready` = (state == IDLE), decoded combinationally from the state register.
- IDLE:
  - On `req_valid && req_ready`, capture `we`, `be`, `wdata` and word index `req_addr[2 +: log2(DEPTH_WORDS)]`.
  - Load the 4-bit counter with WAIT_STATES and move to WAIT.
- WAIT:
  - When the counter is nonzero, decrement it.
  - When the counter is 0, perform the access on this edge and move to RESP:
    - Load `rsp_rdata` with the pre-write word. Both loads and stores return the old contents.
    - If `we`, write each byte lane whose `be` bit is 1; other lanes are unchanged.
    - Set `rsp_valid`.
- RESP:
  - `rsp_valid`, `rsp_rdata` and `rsp_err` are held stable until `rsp_valid && rsp_ready`.
  - After that handshake, clear `rsp_valid` and return to IDLE.
- A store with `be` = 0000 completes normally and writes nothing.
- Only one transaction is outstanding at a time. `req_*` inputs are ignored outside IDLE.
- Address bits above the index are ignored: addresses alias modulo DEPTH_WORDS×4.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, counter 0.
- Latency: `rsp_valid` rises WAIT_STATES+1 clock edges after the accept edge.
- Throughput with `rsp_ready` tied 1: one transaction every WAIT_STATES+3 cycles.
- Reset asserted mid-transaction:
  - The transaction is aborted and outputs return to their reset values immediately.
  - A store still in WAIT is not committed.
  - A store already in RESP remains committed.
- Back-to-back: a new request can be accepted in the cycle after the response handshake, never in the same cycle.

## Configuration
- `DMEM_RANGE_CHK_EN` defined:
  - An access with `req_addr` ≥ DEPTH_WORDS×4 is an error.
  - It completes with normal timing, with `rsp_err` = 1 and `rsp_rdata` = 0.
  - The write is suppressed.
  - `rsp_err` is cleared on the response handshake.
- Not defined: there is no range check. `rsp_err` is tied to 0 and out-of-range addresses alias.

## Test plan
- Reset mid-WAIT (WAIT_STATES=3): store 0x11223344 to 0x20, with `rst_n` pulled low 1 cycle after accept → `rsp_valid` 0, `req_ready` 1 asynchronously; a subsequent load from 0x20 does not return 0x11223344.
- Store then load, WAIT_STATES=2: sw 0xDEADBEEF to 0x10, then lw 0x10 → `rsp_valid` 3 edges after each accept; load `rsp_rdata` = 0xDEADBEEF.
- Byte lanes: following the previous case, store `be`=0010, `wdata`=0x0000AA00 to 0x11 → write response `rsp_rdata` = 0xDEADBEEF; the next load from 0x10 returns 0xDEADAAEF.
- Backpressure: `rsp_ready` held low 5 cycles in RESP while `req_valid` stays high → `rsp_valid`/`rsp_rdata` stable, `req_ready` 0, nothing accepted; the request is accepted the cycle after `rsp_ready` rises.
- Range, DEPTH_WORDS=256: store 0xCAFEF00D to 0x400 after word 0 = 0x0 → without the macro, a load from 0x0 returns 0xCAFEF00D; with the macro, `rsp_err` = 1, `rsp_rdata` = 0, and word 0 is still 0x0.
- Throughput, WAIT_STATES=0, `rsp_ready` = 1, `req_valid` continuously high: four loads → accepts spaced exactly 3 cycles apart, with four responses in order.
